// File: rtl/pulseox_pkg.sv
// Shared widths, window depth and reader FSM encoding for the pulse-ox LED sample path.
package pulseox_pkg;
   localparam int DATA_W     = 22;
   localparam int ADDR_W     = 11;
   localparam int DEPTH      = 1024;
   localparam int LOG2_DEPTH = 10;
   localparam int SUM_W      = 32;
   localparam int CNT_W      = 11;

   typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

   // Window indices wrap at DEPTH, not at the full address range.
   function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
      return (a == ADDR_W'(DEPTH-1)) ? '0 : a + 1'b1;
   endfunction
endpackage

// File: rtl/led_skid2.sv
// 2-entry skid FIFO for RAM read returns; head is visible the cycle after push.
// Push is never refused by design (upstream credit); pop ignored when empty; flush empties it.
module led_skid2 import pulseox_pkg::*; (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] push_dat,
   input  logic              pop,
   output logic [1:0]        count,
   output logic [DATA_W-1:0] head_dat
);
   logic [1:0][DATA_W-1:0] mem;
   logic                   wr_ptr;
   logic                   rd_ptr;
   logic                   do_push;
   logic                   do_pop;

   assign do_pop   = pop && (count != 2'd0);
   assign do_push  = push && ((count != 2'd2) || do_pop);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem    <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end
endmodule

// File: rtl/led_buf_reader.sv
// Streams a DEPTH-sample window from the LED buffer RAM oldest-first and reports its sum and mean.
// First sample 2 cycles after start, 1/cycle when s_ready holds; reads throttled by skid credit.
module led_buf_reader import pulseox_pkg::*; (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] wr_ptr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_q,
   output logic [DATA_W-1:0] s_data,
   output logic              s_valid,
   input  logic              s_ready,
   output logic              s_last,
   output logic              busy,
   output logic              done,
   output logic [SUM_W-1:0]  sum_out,
   output logic [DATA_W-1:0] mean_out
);
   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] nxt_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [CNT_W-1:0]  rd_cnt;
   logic [CNT_W-1:0]  xfer_cnt;
   logic              inflight;
   logic [SUM_W-1:0]  acc;
   logic [SUM_W-1:0]  final_sum;
   logic [1:0]        skid_cnt;
   logic [2:0]        credit_use;
   logic              accept;
   logic              kill;
   logic              pop;
   logic              issue;

   assign accept     = (state == IDLE) && start && !abort;
   assign kill       = ((state == FILL) || (state == DRAIN)) && abort;
   assign pop        = s_valid && s_ready;
   assign credit_use = {1'b0, skid_cnt} + {2'b0, inflight} - {2'b0, pop};
   // The first read goes out in the start cycle itself so data lands in the skid one cycle later.
   assign issue      = accept || ((state == FILL) && !abort && (credit_use < 3'd2));
   assign rd_addr    = (state == IDLE) ? ((wr_ptr >= ADDR_W'(DEPTH)) ? '0 : wr_ptr) : nxt_addr;
   assign ram_addr   = issue ? rd_addr : addr_q;
   assign ram_we     = 1'b0;
   assign s_valid    = (skid_cnt != 2'd0);
   assign s_last     = s_valid && (xfer_cnt == CNT_W'(DEPTH-1));
   assign final_sum  = acc + SUM_W'(s_data);

   led_skid2 u_skid (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (kill),
      .push     (inflight),
      .push_dat (ram_q),
      .pop      (pop),
      .count    (skid_cnt),
      .head_dat (s_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         addr_q   <= '0;
         nxt_addr <= '0;
         rd_cnt   <= '0;
         xfer_cnt <= '0;
         inflight <= 1'b0;
         acc      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum_out  <= '0;
         mean_out <= '0;
      end else begin
         done     <= 1'b0;
         inflight <= issue;
         if (issue) begin
            addr_q   <= rd_addr;
            nxt_addr <= wrap_inc(rd_addr);
            rd_cnt   <= accept ? CNT_W'(1) : rd_cnt + 1'b1;
         end
         if (pop) begin
            acc      <= final_sum;
            xfer_cnt <= xfer_cnt + 1'b1;
         end
         case (state)
            IDLE: if (accept) begin
               state    <= FILL;
               busy     <= 1'b1;
               acc      <= '0;
               xfer_cnt <= '0;
            end
            FILL: if (kill) begin
               state <= IDLE;
               busy  <= 1'b0;
            end else if (issue && (rd_cnt == CNT_W'(DEPTH-1))) begin
               state <= DRAIN;
            end
            DRAIN: if (kill) begin
               state <= IDLE;
               busy  <= 1'b0;
            end else if (pop && s_last) begin
               state    <= DONE;
               done     <= 1'b1;
               sum_out  <= final_sum;
               mean_out <= DATA_W'(final_sum >> LOG2_DEPTH);
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_led_buf_reader.sv
// Directed bench for led_buf_reader against a RAM model holding ram[i] = i+1.
module tb_led_buf_reader;
   import pulseox_pkg::*;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              s_ready = 1'b0;
   logic [ADDR_W-1:0] wr_ptr = '0;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_q = '0;
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_last;
   logic              busy;
   logic              done;
   logic [SUM_W-1:0]  sum_out;
   logic [DATA_W-1:0] mean_out;

   logic [DATA_W-1:0] ram [2048];

   int n_chk = 0, n_err = 0;
   int cyc = 0, exp_base = 0, xfer_idx = 0, stream_err = 0, stall_err = 0;
   int done_cnt = 0, done_lat_err = 0, last_xfer_cyc = -10;
   int addr_err = 0, cnt_err = 0;
   bit held = 0, rdy_rand = 0;
   logic [DATA_W-1:0] held_dat = '0;

   led_buf_reader dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .wr_ptr(wr_ptr),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q), .s_data(s_data),
      .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .busy(busy),
      .done(done), .sum_out(sum_out), .mean_out(mean_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ram_q <= ram[ram_addr];

   always @(posedge clk) begin
      #1;
      if (rdy_rand) s_ready = ($urandom_range(0, 9) < 3);
   end

   always @(negedge clk) begin
      int e;
      cyc++;
      if (ram_addr >= 11'd1024) addr_err++;
      if (dut.u_skid.count > 2'd2) cnt_err++;
      if (held && (!s_valid || s_data != held_dat)) stall_err++;
      held     = s_valid && !s_ready;
      held_dat = s_data;
      if (s_valid && s_ready) begin
         e = ((exp_base + xfer_idx) % 1024) + 1;
         if (int'(s_data) != e) stream_err++;
         if (s_last != (xfer_idx == 1023)) stream_err++;
         xfer_idx++;
         last_xfer_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         if (last_xfer_cyc != cyc - 1) done_lat_err++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic reset_mon();
      xfer_idx = 0; stream_err = 0; stall_err = 0; done_cnt = 0;
      done_lat_err = 0; last_xfer_cyc = -10; held = 0;
   endtask

   task automatic run_window(input string tag, input logic [ADDR_W-1:0] ptr, input bit rnd, input bit mid);
      bit got = 0;
      bit pulsed = 0;
      reset_mon();
      exp_base = (ptr >= 11'd1024) ? 0 : int'(ptr);
      rdy_rand = rnd;
      if (!rnd) s_ready = 1'b1;
      wr_ptr = ptr;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, " busy@1"}, 32'(busy), 1);
      chk({tag, " vld@1"}, 32'(s_valid), 0);
      @(posedge clk); #1;
      chk({tag, " vld@2"}, 32'(s_valid), 1);
      chk({tag, " dat@2"}, 32'(s_data), 32'(exp_base + 1));
      for (int i = 0; i < 10000 && !got; i++) begin
         if (done) got = 1;
         else begin
            @(posedge clk); #1;
            start = 1'b0;
            if (mid && !pulsed && xfer_idx >= 500) begin
               start  = 1'b1;
               pulsed = 1;
            end
         end
      end
      rdy_rand = 0;
      chk({tag, " done seen"}, 32'(got), 1);
      chk({tag, " sum"}, sum_out, 524800);
      chk({tag, " mean"}, 32'(mean_out), 512);
      chk({tag, " busy@done"}, 32'(busy), 1);
      @(posedge clk); #1;
      chk({tag, " busy after"}, 32'(busy), 0);
      chk({tag, " done 1cyc"}, 32'(done), 0);
      chk({tag, " xfers"}, 32'(xfer_idx), 1024);
      chk({tag, " stream"}, 32'(stream_err), 0);
      chk({tag, " done count"}, 32'(done_cnt), 1);
      chk({tag, " done latency"}, 32'(done_lat_err), 0);
      chk({tag, " stall hold"}, 32'(stall_err), 0);
   endtask

   initial begin
      bit hit;
      for (int i = 0; i < 2048; i++) ram[i] = (i < 1024) ? DATA_W'(i + 1) : '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      chk("rst valid", 32'(s_valid), 0);
      chk("rst sum", sum_out, 0);
      chk("rst mean", 32'(mean_out), 0);
      chk("rst addr", 32'(ram_addr), 0);
      chk("rst we", 32'(ram_we), 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      run_window("T1", 11'd0, 0, 0);
      run_window("T2", 11'd1020, 0, 0);
      chk("T2 addr range", 32'(addr_err), 0);
      run_window("T3", 11'd0, 1, 0);
      chk("T3 skid count", 32'(cnt_err), 0);

      // T4: abort part way through
      reset_mon();
      exp_base = 0; s_ready = 1'b1; wr_ptr = '0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      hit = 0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         if (xfer_idx >= 100) hit = 1;
         else begin @(posedge clk); #1; end
      end
      chk("T4 reached 100", 32'(hit), 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("T4 busy", 32'(busy), 0);
      chk("T4 valid", 32'(s_valid), 0);
      repeat (20) @(posedge clk);
      #1;
      chk("T4 no done", 32'(done_cnt), 0);
      chk("T4 stream", 32'(stream_err), 0);
      chk("T4 sum kept", sum_out, 524800);
      chk("T4 mean kept", 32'(mean_out), 512);
      run_window("T4b", 11'd0, 0, 0);

      // T5: restart mid-window (out-of-range wr_ptr), then start+abort in IDLE
      run_window("T5", 11'd2000, 0, 1);
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      chk("T5 idle busy", 32'(busy), 0);
      @(posedge clk); #1;
      chk("T5 idle valid", 32'(s_valid), 0);

      // T6: reset while draining
      reset_mon();
      exp_base = 0; s_ready = 1'b1; wr_ptr = '0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      hit = 0;
      for (int i = 0; i < 3000 && !hit; i++) begin
         if (xfer_idx >= 1022) hit = 1;
         else begin @(posedge clk); #1; end
      end
      s_ready = 1'b0;
      @(posedge clk); #1;
      chk("T6 in drain", 32'(dut.state), 32'(DRAIN));
      #2 reset_n = 1'b0;
      #1;
      reset_mon();
      chk("T6 busy", 32'(busy), 0);
      chk("T6 valid", 32'(s_valid), 0);
      chk("T6 data", 32'(s_data), 0);
      chk("T6 done", 32'(done), 0);
      chk("T6 sum", sum_out, 0);
      chk("T6 addr", 32'(ram_addr), 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      run_window("T6b", 11'd5, 0, 0);
      chk("all addr range", 32'(addr_err), 0);
      chk("all skid count", 32'(cnt_err), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
